// File: rtl/decimal_entry.sv
// ---------------------------------------------------------------------------
// decimal_entry
//
// Operator input path for building a decimal number one digit at a time.
// The operator sets a BCD digit on four switches and presses the digit key.
// Each accepted digit folds into a 32-bit binary accumulator as
// value*10 + digit. A commit key publishes the value with a one-cycle
// strobe, and a clear key empties the entry. The three raw pushbuttons are
// active-low; each is synchronised and debounced inside this block.
//
// Ports
//    clk           system clock, rising edge
//    reset         asynchronous reset, active low
//    digit_sw      BCD digit from switches, sampled only on a digit event
//    key_digit_n   raw pushbutton, active low, appends a digit
//    key_commit_n  raw pushbutton, active low, commits the value
//    key_clear_n   raw pushbutton, active low, clears the entry
//    value         accumulated value, zero-extended binary
//    digit_count   digits accepted in the current entry
//    value_valid   one-cycle pulse when the value is committed
//    entry_active  high while an entry is in progress
//    err           sticky error flag, cleared only by clear or reset
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// key_debounce
//
// Two-flop synchroniser followed by a stability counter for one active-low
// key. The accepted level only follows the synchronised level after it has
// disagreed for DEBOUNCE_CYCLES consecutive samples. A single-cycle press
// strobe marks each accepted 1->0 transition. Releases produce no strobe.
//
// Ports
//    clk     system clock
//    reset   asynchronous reset, active low
//    key_n   raw active-low key
//    press   one-cycle strobe per debounced press
// ---------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   // Everything idles at the released level (1), so a key that is already
   // held low when reset is released is still seen as a fresh press.
   // The counter only runs while the synchronised key disagrees with the
   // accepted level; any agreement restarts the stability window, which is
   // what rejects short glitches and contact bounce.
   // The press strobe is registered off the accepted level and its delayed
   // copy, giving one clean pulse one cycle after the level flips.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync1   <= key_n;
         sync2   <= sync1;
         level_d <= level;
         press   <= level_d & ~level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

module decimal_entry #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MAX_DIGITS      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  digit_sw,
   input  logic        key_digit_n,
   input  logic        key_commit_n,
   input  logic        key_clear_n,
   output logic [31:0] value,
   output logic [3:0]  digit_count,
   output logic        value_valid,
   output logic        entry_active,
   output logic        err
);

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      ENTRY     = 2'd1,
      COMMITTED = 2'd2
   } entry_state_t;

   localparam logic [3:0] MAX_COUNT = 4'(MAX_DIGITS);

   entry_state_t state;
   entry_state_t state_next;
   logic [31:0]  value_next;
   logic [3:0]   count_next;
   logic         err_next;
   logic         valid_next;
   logic [31:0]  value_times10;

   logic digit_ev;
   logic commit_ev;
   logic clear_ev;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_digit (
      .clk   (clk),
      .reset (reset),
      .key_n (key_digit_n),
      .press (digit_ev)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_commit (
      .clk   (clk),
      .reset (reset),
      .key_n (key_commit_n),
      .press (commit_ev)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
      .clk   (clk),
      .reset (reset),
      .key_n (key_clear_n),
      .press (clear_ev)
   );

   // Multiply by ten as shift-and-add; the digit limit keeps the result
   // well inside 32 bits, so no overflow handling is needed.
   assign value_times10 = (value << 3) + (value << 1);

   // Next-state logic. Events are prioritised clear > commit > digit, and a
   // lower-priority event arriving in the same cycle is simply dropped.
   // An out-of-range digit or an overfull entry only raises err and leaves
   // the entry untouched, so the operator can carry on after a mistake.
   always_comb begin
      state_next = state;
      value_next = value;
      count_next = digit_count;
      err_next   = err;
      valid_next = 1'b0;

      if (clear_ev) begin
         state_next = EMPTY;
         value_next = '0;
         count_next = '0;
         err_next   = 1'b0;
      end else if (commit_ev) begin
         case (state)
            ENTRY: begin
               valid_next = 1'b1;
               state_next = COMMITTED;
            end
            EMPTY:   err_next = 1'b1;
            default: ;
         endcase
      end else if (digit_ev) begin
         if (digit_sw > 4'd9) begin
            err_next = 1'b1;
         end else if (state == ENTRY) begin
            if (digit_count < MAX_COUNT) begin
               value_next = value_times10 + {28'd0, digit_sw};
               count_next = digit_count + 4'd1;
            end else begin
               err_next = 1'b1;
            end
         end else begin
            value_next = {28'd0, digit_sw};
            count_next = 4'd1;
            state_next = ENTRY;
         end
      end
   end

   // State and output registers. entry_active is registered from the next
   // state so it always lines up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= EMPTY;
         value        <= '0;
         digit_count  <= '0;
         err          <= 1'b0;
         value_valid  <= 1'b0;
         entry_active <= 1'b0;
      end else begin
         state        <= state_next;
         value        <= value_next;
         digit_count  <= count_next;
         err          <= err_next;
         value_valid  <= valid_next;
         entry_active <= (state_next == ENTRY);
      end
   end

endmodule

// File: tb/tb_decimal_entry.sv
// ---------------------------------------------------------------------------
// tb_decimal_entry
//
// Directed bench for decimal_entry with a short debounce window (4 cycles)
// and a 4-digit limit. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_decimal_entry;

   localparam int DEB = 4;
   localparam int MAXD = 4;

   logic        clk;
   logic        reset;
   logic [3:0]  digit_sw;
   logic        key_digit_n;
   logic        key_commit_n;
   logic        key_clear_n;
   logic [31:0] value;
   logic [3:0]  digit_count;
   logic        value_valid;
   logic        entry_active;
   logic        err;

   int checkCount;
   int failCount;
   int validPulses;

   localparam logic [2:0] K_DIGIT  = 3'b001;
   localparam logic [2:0] K_COMMIT = 3'b010;
   localparam logic [2:0] K_CLEAR  = 3'b100;

   decimal_entry #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
      .clk          (clk),
      .reset        (reset),
      .digit_sw     (digit_sw),
      .key_digit_n  (key_digit_n),
      .key_commit_n (key_commit_n),
      .key_clear_n  (key_clear_n),
      .value        (value),
      .digit_count  (digit_count),
      .value_valid  (value_valid),
      .entry_active (entry_active),
      .err          (err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts falling edges with value_valid high, so a wide pulse counts twice.
   always @(negedge clk) begin
      if (value_valid) validPulses++;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Press the selected keys together for lowCycles samples, release them and
   // wait long enough for the release to be debounced as well.
   task automatic applyStimulus(input logic [2:0] keys, input logic [3:0] dig,
                                input int lowCycles);
      @(negedge clk);
      digit_sw     = dig;
      key_digit_n  = ~keys[0];
      key_commit_n = ~keys[1];
      key_clear_n  = ~keys[2];
      repeat (lowCycles) @(negedge clk);
      key_digit_n  = 1'b1;
      key_commit_n = 1'b1;
      key_clear_n  = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic enterDigit(input logic [3:0] dig);
      applyStimulus(K_DIGIT, dig, 8);
   endtask

   initial begin
      int pulsesBefore;
      checkCount   = 0;
      failCount    = 0;
      validPulses  = 0;
      reset        = 1'b0;
      digit_sw     = 4'd0;
      key_digit_n  = 1'b1;
      key_commit_n = 1'b1;
      key_clear_n  = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset value", value, 32'd0);
      checkOutput("reset count", {28'd0, digit_count}, 32'd0);
      checkOutput("reset valid", {31'd0, value_valid}, 32'd0);
      checkOutput("reset active", {31'd0, entry_active}, 32'd0);
      checkOutput("reset err", {31'd0, err}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Build 1234 digit by digit, then commit.
      enterDigit(4'd1);
      checkOutput("d1 value", value, 32'd1);
      checkOutput("d1 active", {31'd0, entry_active}, 32'd1);
      enterDigit(4'd2);
      checkOutput("d2 value", value, 32'd12);
      enterDigit(4'd3);
      checkOutput("d3 value", value, 32'd123);
      enterDigit(4'd4);
      checkOutput("d4 value", value, 32'd1234);
      checkOutput("d4 count", {28'd0, digit_count}, 32'd4);
      pulsesBefore = validPulses;
      applyStimulus(K_COMMIT, 4'd0, 8);
      checkOutput("commit pulse width", validPulses - pulsesBefore, 32'd1);
      checkOutput("commit value held", value, 32'd1234);
      checkOutput("commit count held", {28'd0, digit_count}, 32'd4);
      checkOutput("commit active", {31'd0, entry_active}, 32'd0);
      checkOutput("commit err", {31'd0, err}, 32'd0);

      // A second commit while committed is ignored.
      pulsesBefore = validPulses;
      applyStimulus(K_COMMIT, 4'd0, 8);
      checkOutput("recommit no pulse", validPulses - pulsesBefore, 32'd0);

      // A digit after a commit starts a new entry.
      enterDigit(4'd5);
      checkOutput("restart value", value, 32'd5);
      checkOutput("restart count", {28'd0, digit_count}, 32'd1);
      checkOutput("restart active", {31'd0, entry_active}, 32'd1);

      applyStimulus(K_CLEAR, 4'd0, 8);
      checkOutput("clear value", value, 32'd0);
      checkOutput("clear count", {28'd0, digit_count}, 32'd0);
      checkOutput("clear active", {31'd0, entry_active}, 32'd0);

      // Commit with nothing entered is an error and produces no pulse.
      pulsesBefore = validPulses;
      applyStimulus(K_COMMIT, 4'd0, 8);
      checkOutput("empty commit err", {31'd0, err}, 32'd1);
      checkOutput("empty commit no pulse", validPulses - pulsesBefore, 32'd0);
      applyStimulus(K_CLEAR, 4'd0, 8);
      checkOutput("clear err", {31'd0, err}, 32'd0);

      // Held key: the update lands exactly DEB+3 edges after the first sample.
      @(negedge clk);
      digit_sw    = 4'd7;
      key_digit_n = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("latency edge 6", value, 32'd0);
      @(negedge clk);
      checkOutput("latency edge 7", value, 32'd7);
      repeat (100) @(negedge clk);
      key_digit_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("hold single event", {28'd0, digit_count}, 32'd1);

      // A 3-cycle glitch is shorter than the window and must be ignored.
      applyStimulus(K_DIGIT, 4'd3, 3);
      checkOutput("glitch value", value, 32'd7);
      checkOutput("glitch count", {28'd0, digit_count}, 32'd1);

      // Bounce 1-0-1-0 then settle low: one event only.
      applyStimulus(K_CLEAR, 4'd0, 8);
      @(negedge clk);
      digit_sw    = 4'd2;
      key_digit_n = 1'b0;
      @(negedge clk) key_digit_n = 1'b1;
      @(negedge clk) key_digit_n = 1'b0;
      @(negedge clk) key_digit_n = 1'b1;
      @(negedge clk) key_digit_n = 1'b0;
      repeat (10) @(negedge clk);
      key_digit_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("bounce value", value, 32'd2);
      checkOutput("bounce count", {28'd0, digit_count}, 32'd1);

      // Non-BCD digit raises err and leaves the entry alone.
      enterDigit(4'hC);
      checkOutput("bad digit err", {31'd0, err}, 32'd1);
      checkOutput("bad digit value", value, 32'd2);

      // Fifth digit after 9999 is rejected.
      applyStimulus(K_CLEAR, 4'd0, 8);
      for (int i = 0; i < 4; i++) enterDigit(4'd9);
      checkOutput("9999 value", value, 32'd9999);
      checkOutput("9999 err", {31'd0, err}, 32'd0);
      enterDigit(4'd9);
      checkOutput("overflow err", {31'd0, err}, 32'd1);
      checkOutput("overflow value", value, 32'd9999);
      checkOutput("overflow count", {28'd0, digit_count}, 32'd4);
      applyStimulus(K_CLEAR, 4'd0, 8);
      checkOutput("clear2 value", value, 32'd0);
      checkOutput("clear2 count", {28'd0, digit_count}, 32'd0);
      checkOutput("clear2 err", {31'd0, err}, 32'd0);

      // Clear and digit on the same edge: clear wins.
      enterDigit(4'd1);
      enterDigit(4'd2);
      checkOutput("pre-tie value", value, 32'd12);
      applyStimulus(K_CLEAR | K_DIGIT, 4'd5, 8);
      checkOutput("tie value", value, 32'd0);
      checkOutput("tie count", {28'd0, digit_count}, 32'd0);

      // Reset mid-entry and mid-debounce clears outputs before the next edge.
      enterDigit(4'd1);
      enterDigit(4'd2);
      @(negedge clk);
      digit_sw    = 4'd3;
      key_digit_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("async reset value", value, 32'd0);
      checkOutput("async reset count", {28'd0, digit_count}, 32'd0);
      checkOutput("async reset active", {31'd0, entry_active}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("held after reset value", value, 32'd3);
      checkOutput("held after reset count", {28'd0, digit_count}, 32'd1);
      key_digit_n = 1'b1;
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
      $finish;
   end

endmodule
